// File: rtl/ahb_fifo_latency_meter.sv
// Stopwatch companion to the AHB FIFO delay counter: measures start-to-stop latency
// in cycles and keeps running min/max/count statistics with an optional timeout abort.
module ahb_fifo_latency_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             meas_start,
  input  logic             meas_stop,
  input  logic             meas_clr,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_value,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [NUM_W-1:0] lat_num,
  output logic             lat_busy,
  output logic             lat_timeout,
  output logic             lat_ovf
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // TIMEOUT is truncated to the counter width; keep it below 2**CNT_W.
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t           state;
  logic             start_ff;
  logic [CNT_W-1:0] cnt;

  logic             start_edge;
  logic             sample_done;
  logic             timeout_hit;
  logic [CNT_W-1:0] base_min;
  logic [CNT_W-1:0] base_max;
  logic [NUM_W-1:0] base_num;
  logic             base_ovf;

  // A clear coinciding with a completion folds the sample into the cleared statistics.
  always_comb begin
    start_edge  = meas_start && !start_ff;
    sample_done = (state == RUN) && !start_edge && meas_stop;
    timeout_hit = (TIMEOUT != 0) && (state == RUN) && !start_edge && !meas_stop
                  && (cnt == TO_VAL);
    base_min    = meas_clr ? '1   : lat_min;
    base_max    = meas_clr ? '0   : lat_max;
    base_num    = meas_clr ? '0   : lat_num;
    base_ovf    = meas_clr ? 1'b0 : lat_ovf;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state       <= IDLE;
      start_ff    <= 1'b0;
      cnt         <= '0;
      lat_valid   <= 1'b0;
      lat_value   <= '0;
      lat_min     <= '1;
      lat_max     <= '0;
      lat_num     <= '0;
      lat_busy    <= 1'b0;
      lat_timeout <= 1'b0;
      lat_ovf     <= 1'b0;
    end else begin
      start_ff    <= meas_start;
      lat_valid   <= sample_done;
      lat_timeout <= timeout_hit;

      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= RUN;
            lat_busy <= 1'b1;
            cnt      <= CNT_W'(1);
          end
        end
        RUN: begin
          if (start_edge) begin
            cnt <= CNT_W'(1);
          end else if (meas_stop) begin
            state     <= IDLE;
            lat_busy  <= 1'b0;
            lat_value <= cnt;
          end else if (timeout_hit) begin
            state    <= IDLE;
            lat_busy <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          lat_busy <= 1'b0;
        end
      endcase

      if (sample_done) begin
        lat_min <= (cnt < base_min) ? cnt : base_min;
        lat_max <= (cnt > base_max) ? cnt : base_max;
        lat_num <= (base_num == '1) ? base_num : base_num + NUM_W'(1);
        lat_ovf <= base_ovf | (cnt == '1);
      end else if (meas_clr) begin
        lat_min <= '1;
        lat_max <= '0;
        lat_num <= '0;
        lat_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ahb_fifo_latency_meter.md
Name: ahb_fifo_latency_meter

Overview:
- Stopwatch counterpart of the AHB FIFO countdown delay counter.
- The delay counter generates a programmed response delay; this block measures the actual delay between a request-start event and a response-stop event.
- Keeps running min/max/count statistics and an optional timeout abort.
- Instantiated next to the AHB FIFO in the smart_run testbench fabric. Software reads its outputs through a register wrapper.

Parameters:
- CNT_W, 32, width of the elapsed counter and of lat_value/lat_min/lat_max.
- NUM_W, 16, width of the measurement-count statistic.
- TIMEOUT, 0, abort threshold in cycles; 0 disables the timeout.

Ports:
- cpu_clk  input  1  sole clock, rising edge.
- cpu_rst  input  1  asynchronous, active-high reset.
- meas_start  input  1  level; a measurement starts on its rising edge (meas_start && !start_ff).
- meas_stop  input  1  level, sampled each cycle; ends a running measurement.
- meas_clr  input  1  synchronous clear of the statistics.
- lat_valid  output  1  one-cycle pulse; lat_value holds a new sample.
- lat_value  output  CNT_W  last completed latency, in cycles.
- lat_min  output  CNT_W  minimum sample since the last clear.
- lat_max  output  CNT_W  maximum sample since the last clear.
- lat_num  output  NUM_W  completed samples since the last clear; saturating.
- lat_busy  output  1  high while in RUN.
- lat_timeout  output  1  one-cycle pulse on a timeout abort.
- lat_ovf  output  1  sticky; a saturated sample was reported.

Behaviour:
- Reset values (asynchronous, while cpu_rst=1):
  - State IDLE; start_ff=0; cnt=0.
  - lat_valid=0, lat_value=0, lat_min=all-ones, lat_max=0, lat_num=0, lat_busy=0, lat_timeout=0, lat_ovf=0.
- Edge detection: start_ff registers meas_start every cycle. start_edge = meas_start && !start_ff.
- FSM with two states: IDLE and RUN. lat_busy = (state==RUN).
- IDLE:
  - start_edge -> RUN, cnt<=1.
  - meas_stop is ignored in IDLE, including in the start_edge cycle.
- RUN, priority order (first matching rule applies):
  1. start_edge: restart. cnt<=1, stay in RUN, nothing reported, even if meas_stop=1 in the same cycle.
  2. meas_stop: lat_value<=cnt, lat_valid=1 in the next cycle, -> IDLE.
  3. TIMEOUT!=0 and cnt==TIMEOUT: -> IDLE, lat_timeout=1 in the next cycle, no sample, statistics unchanged.
  4. Otherwise: cnt<=cnt+1, saturating at all-ones (never wraps).
- Latency definition: with the start edge in cycle 0 and meas_stop high in cycle k (k>=1), lat_value=k. lat_valid is high in cycle k+1.
- Statistics update in the same edge that writes lat_value:
  - lat_min<=min(lat_min,cnt); lat_max<=max(lat_max,cnt); lat_num<=lat_num+1, saturating at all-ones.
  - If the reported cnt is all-ones, lat_ovf<=1.
- meas_clr:
  - Sets lat_min=all-ones, lat_max=0, lat_num=0, lat_ovf=0.
  - Does not affect the FSM, cnt or lat_value.
  - If clr coincides with a sample completion, the sample is applied to the cleared state: min=max=sample, num=1, ovf per that sample.
- lat_valid and lat_timeout are never high in the same cycle.
- A reset in the middle of RUN aborts the measurement with no pulse, and all outputs return to their reset values.
- All outputs are registered. There are no combinational paths from input to output.

Test Plan:
- Basic measurement: meas_start 0->1 in cycle 0, meas_stop pulse in cycle 5 -> lat_valid in cycle 6, lat_value=5, lat_min=lat_max=5, lat_num=1.
- Statistics over several samples: samples of 3, 9, 1 -> lat_min=1, lat_max=9, lat_num=3. Then meas_clr coincident with a stop at 4 -> min=max=4, num=1.
- Restart and ignore rules:
  - Start edge at cycle 0, start held low then high again at cycle 4, stop at cycle 7 -> one sample, lat_value=3.
  - Stop in IDLE -> no lat_valid.
- Timeout: TIMEOUT=10, start, no stop -> lat_timeout pulse in cycle 11, lat_num unchanged, lat_busy=0. With stop at cycle 10 -> lat_valid with lat_value=10, no timeout.
- Saturation: CNT_W=4, stop at cycle 20 -> lat_value=15, lat_ovf=1 until meas_clr.
- Reset mid-RUN: assert cpu_rst asynchronously at cycle 3 of RUN -> lat_busy=0 immediately. After release, a stop produces no lat_valid.
